// File: rtl/mac_pkg.sv
// mac_pkg: shared state encoding, framing constants and CRC-32 step for the receive MAC
package mac_pkg;
  typedef enum logic [2:0] {IDLE, PREAMBLE, DEST_MAC, SRC_MAC, FRAME_TYPE, DATA, CHECK, DISCARD} state_t;
  localparam logic [7:0] PREAMBLE_BYTE = 8'hbc;
  localparam logic [31:0] CRC32_POLY = 32'hedb88320;
  localparam logic [31:0] CRC32_INIT = 32'hffffffff;
  localparam logic [31:0] CRC32_RESIDUE = 32'hdebb20e3;
  localparam logic [47:0] BROADCAST_MAC = 48'hffffffffffff;
  localparam int DEST_LEN = 6;
  localparam int SRC_LEN = 6;
  localparam int TYPE_LEN = 2;
  localparam int FCS_LEN = 4;
  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ CRC32_POLY : r >> 1;
    return r;
  endfunction
endpackage

// File: rtl/mac_rx_if.sv
// mac_rx_if: byte stream in, payload stream plus frame status out
interface mac_rx_if #(parameter int COUNTER_WIDTH = 11);
  logic [7:0] mac_in;
  logic rx_ctl;
  logic [7:0] rx_data;
  logic rx_valid;
  logic rx_sof;
  logic rx_eof;
  logic [47:0] rx_src_mac;
  logic [15:0] rx_frame_type;
  logic [COUNTER_WIDTH-1:0] rx_len;
  logic frame_good;
  logic frame_bad;
  logic addr_miss;
  modport master (output mac_in, rx_ctl,
                  input rx_data, rx_valid, rx_sof, rx_eof, rx_src_mac, rx_frame_type, rx_len, frame_good, frame_bad, addr_miss);
  modport slave (input mac_in, rx_ctl,
                 output rx_data, rx_valid, rx_sof, rx_eof, rx_src_mac, rx_frame_type, rx_len, frame_good, frame_bad, addr_miss);
endinterface

// File: rtl/mac_crc_rx.sv
// mac_crc_rx: byte-wide reflected CRC-32 register, left unfinalised so the residue can be checked
module mac_crc_rx import mac_pkg::*; (
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  data_in,
  output logic [31:0] crc_out
);
  // seed on init, otherwise fold in one byte per enabled cycle
  always_ff @(posedge clk or posedge rst)
    if (rst) crc_out <= '0;
    else if (init) crc_out <= CRC32_INIT;
    else if (en) crc_out <= crc32_byte(crc_out, data_in);
endmodule

// File: rtl/mac_rx.sv
// mac_rx: receive framer with preamble check, address filter, FCS strip and CRC-32 check
module mac_rx import mac_pkg::*; #(
  parameter logic [47:0] MAC_ADDR      = 48'hdeadbeefcafe,
  parameter logic [7:0]  PREAMBLE_BYTE = mac_pkg::PREAMBLE_BYTE,
  parameter int          PREAMBLE_LEN  = 8,
  parameter int          MAX_PAYLOAD   = 1500,
  parameter int          COUNTER_WIDTH = 11
) (
  input logic       clk,
  input logic       rst,
  mac_rx_if.slave   bus
);
  localparam int PIPE = FCS_LEN + 1;
  state_t state, nstate;
  logic [COUNTER_WIDTH-1:0] cnt, paycnt;
  logic [2:0] pcnt;
  logic [8*PIPE-1:0] pipe;
  logic [47:0] mac_sh, src_sh;
  logic [7:0] type_hi;
  logic [31:0] crc;
  logic uc_ok, bc_ok, uc_n, bc_n, miss_flag, pre_ok, pre_last, full, room, chk;
  logic emit_d, emit_c, hdr_drop, good_n, bad_n, miss_n, cap, crc_init, crc_en;

  mac_crc_rx u_crc (.clk(clk), .rst(rst), .init(crc_init), .en(crc_en), .data_in(bus.mac_in), .crc_out(crc));

  assign mac_sh   = MAC_ADDR << {cnt[2:0], 3'b000};
  assign pre_ok   = bus.mac_in == PREAMBLE_BYTE;
  assign pre_last = cnt == COUNTER_WIDTH'(PREAMBLE_LEN - 1);
  assign uc_n     = uc_ok && bus.mac_in == mac_sh[47:40];
  assign bc_n     = bc_ok && bus.mac_in == BROADCAST_MAC[7:0];
  assign full     = pcnt == 3'(PIPE);
  assign room     = paycnt != COUNTER_WIDTH'(MAX_PAYLOAD);
  assign chk      = state == DATA && !bus.rx_ctl;

  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nstate;

  // next-state decode
  always_comb begin
    nstate = state;
    case (state)
      IDLE:       nstate = !bus.rx_ctl ? IDLE : !pre_ok ? DISCARD : pre_last ? DEST_MAC : PREAMBLE;
      PREAMBLE:   nstate = !(bus.rx_ctl && pre_ok) ? DISCARD : pre_last ? DEST_MAC : PREAMBLE;
      DEST_MAC:   nstate = !bus.rx_ctl ? IDLE : cnt != COUNTER_WIDTH'(DEST_LEN - 1) ? DEST_MAC : (uc_n || bc_n) ? SRC_MAC : DISCARD;
      SRC_MAC:    nstate = !bus.rx_ctl ? IDLE : cnt != COUNTER_WIDTH'(SRC_LEN - 1) ? SRC_MAC : FRAME_TYPE;
      FRAME_TYPE: nstate = !bus.rx_ctl ? IDLE : cnt != COUNTER_WIDTH'(TYPE_LEN - 1) ? FRAME_TYPE : DATA;
      DATA:       nstate = !bus.rx_ctl ? CHECK : (full && !room) ? DISCARD : DATA;
      CHECK:      nstate = IDLE;
      default:    nstate = bus.rx_ctl ? DISCARD : IDLE;
    endcase
  end

  // per-cycle output and control decisions, registered below
  always_comb begin
    emit_d   = state == DATA && bus.rx_ctl && full && room;
    emit_c   = chk && full && room;
    hdr_drop = (state inside {DEST_MAC, SRC_MAC, FRAME_TYPE}) && !bus.rx_ctl;
    good_n   = emit_c && crc == CRC32_RESIDUE;
    miss_n   = state == DISCARD && !bus.rx_ctl && miss_flag;
    bad_n    = (chk && !good_n) || hdr_drop || (state == DISCARD && !bus.rx_ctl && !miss_flag);
    cap      = state == FRAME_TYPE && bus.rx_ctl && cnt == COUNTER_WIDTH'(TYPE_LEN - 1);
    crc_init = (state inside {IDLE, PREAMBLE}) && nstate == DEST_MAC;
    crc_en   = (state inside {DEST_MAC, SRC_MAC, FRAME_TYPE, DATA}) && bus.rx_ctl;
  end

  // counters, address match flags, header shifters and the FCS-hiding delay line
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      paycnt <= '0;
      pcnt <= '0;
      pipe <= '0;
      src_sh <= '0;
      type_hi <= '0;
      uc_ok <= 1'b1;
      bc_ok <= 1'b1;
      miss_flag <= 1'b0;
    end else begin
      cnt <= (nstate == IDLE || (nstate != state && state != IDLE)) ? '0 : cnt + 1'b1;
      paycnt <= state == IDLE ? '0 : paycnt + COUNTER_WIDTH'(emit_d);
      pcnt <= state != DATA ? '0 : (bus.rx_ctl && !full) ? pcnt + 1'b1 : pcnt;
      if (state == DATA && bus.rx_ctl) pipe <= {pipe[8*PIPE-9:0], bus.mac_in};
      if (state == SRC_MAC && bus.rx_ctl) src_sh <= {src_sh[39:0], bus.mac_in};
      if (state == FRAME_TYPE && bus.rx_ctl) type_hi <= bus.mac_in;
      uc_ok <= state != DEST_MAC || uc_n;
      bc_ok <= state != DEST_MAC || bc_n;
      miss_flag <= state == DISCARD ? miss_flag : state == DEST_MAC && nstate == DISCARD;
    end

  // registered user-facing outputs
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bus.rx_data <= '0;
      bus.rx_valid <= 1'b0;
      bus.rx_sof <= 1'b0;
      bus.rx_eof <= 1'b0;
      bus.rx_len <= '0;
      bus.rx_src_mac <= '0;
      bus.rx_frame_type <= '0;
      bus.frame_good <= 1'b0;
      bus.frame_bad <= 1'b0;
      bus.addr_miss <= 1'b0;
    end else begin
      bus.rx_valid <= emit_d || emit_c;
      if (emit_d || emit_c) bus.rx_data <= pipe[8*PIPE-1 -: 8];
      bus.rx_sof <= (emit_d || emit_c) && paycnt == '0;
      bus.rx_eof <= emit_c;
      bus.rx_len <= emit_c ? paycnt + 1'b1 : '0;
      bus.frame_good <= good_n;
      bus.frame_bad <= bad_n;
      bus.addr_miss <= miss_n;
      if (cap) begin
        bus.rx_src_mac <= src_sh;
        bus.rx_frame_type <= {type_hi, bus.mac_in};
      end
    end
endmodule

// File: tb/tb_mac_rx.sv
// tb_mac_rx: directed frames against mac_rx with hand-derived expectations
module tb_mac_rx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  mac_rx_if bus ();
  mac_rx dut (.clk(clk), .rst(rst), .bus(bus));

  localparam logic [47:0] DA   = 48'hdeadbeefcafe;
  localparam logic [47:0] SRC1 = 48'h020000000001;

  int n_assert = 0;
  int n_fail = 0;
  logic [7:0] fq[$];
  logic [7:0] rxq[$];
  int sof_idx, eof_idx, n_sof, n_eof, n_good, n_bad, n_miss, n_multi, last_len;
  bit mon_clr = 1'b0;
  logic [2:0] pre_vec, end_vec;

  always #5 clk = ~clk;

  // record everything the DUT emits, sampled mid-cycle
  always @(negedge clk) begin
    if (mon_clr || rst) begin
      rxq.delete();
      sof_idx = -1; eof_idx = -1; n_sof = 0; n_eof = 0;
      n_good = 0; n_bad = 0; n_miss = 0; last_len = -1;
    end else begin
      if (bus.rx_valid) begin
        if (bus.rx_sof) begin n_sof++; sof_idx = rxq.size(); end
        if (bus.rx_eof) begin n_eof++; eof_idx = rxq.size(); last_len = int'(bus.rx_len); end
        rxq.push_back(bus.rx_data);
      end
      if (bus.frame_good) n_good++;
      if (bus.frame_bad) n_bad++;
      if (bus.addr_miss) n_miss++;
    end
    if ($countones({bus.frame_good, bus.frame_bad, bus.addr_miss}) > 1) n_multi++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] crc_ref(input logic [31:0] c, input logic [7:0] d);
    logic fb;
    for (int b = 0; b < 8; b++) begin
      fb = c[0] ^ d[b];
      c = {1'b0, c[31:1]} ^ (fb ? 32'hedb88320 : 32'h0);
    end
    return c;
  endfunction

  task automatic mk(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] typ, input int plen);
    logic [31:0] c;
    fq.delete();
    repeat (8) fq.push_back(8'hbc);
    for (int i = 0; i < 6; i++) fq.push_back(dst[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) fq.push_back(src[47-8*i -: 8]);
    fq.push_back(typ[15:8]);
    fq.push_back(typ[7:0]);
    for (int i = 0; i < plen; i++) fq.push_back(i[7:0]);
    c = 32'hffffffff;
    for (int i = 8; i < fq.size(); i++) c = crc_ref(c, fq[i]);
    c = ~c;
    for (int i = 0; i < 4; i++) fq.push_back(c[8*i +: 8]);
  endtask

  task automatic send();
    foreach (fq[i]) begin
      bus.mac_in = fq[i];
      bus.rx_ctl = 1'b1;
      @(posedge clk); #1;
    end
    bus.rx_ctl = 1'b0;
    bus.mac_in = 8'h00;
    pre_vec = {bus.frame_good, bus.frame_bad, bus.addr_miss};
    @(posedge clk); #1;
    end_vec = {bus.frame_good, bus.frame_bad, bus.addr_miss};
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clr();
    mon_clr = 1'b1;
    @(negedge clk); #1;
    mon_clr = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic chk_payload(input string tag);
    int bad;
    bad = 0;
    foreach (rxq[i]) if (rxq[i] !== i[7:0]) bad++;
    chk(tag, bad, 0);
  endtask

  initial begin
    bus.mac_in = 8'h00;
    bus.rx_ctl = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_status", {bus.rx_valid, bus.rx_sof, bus.rx_eof, bus.frame_good, bus.frame_bad, bus.addr_miss}, 0);
    chk("reset_src_mac", bus.rx_src_mac, 0);
    chk("reset_type", bus.rx_frame_type, 0);
    chk("reset_len_data", {bus.rx_len, bus.rx_data}, 0);
    idle(2);

    clr(); mk(DA, SRC1, 16'h0800, 46); send();
    chk("t1_pre_pulse", pre_vec, 3'b000);
    chk("t1_end_pulse", end_vec, 3'b100);
    idle(3);
    chk("t1_count", rxq.size(), 46);
    chk_payload("t1_bytes");
    chk("t1_sof_idx", sof_idx, 0);
    chk("t1_eof_idx", eof_idx, 45);
    chk("t1_sof_eof_n", {n_sof[7:0], n_eof[7:0]}, 16'h0101);
    chk("t1_len", last_len, 46);
    chk("t1_type", bus.rx_frame_type, 16'h0800);
    chk("t1_src", bus.rx_src_mac, SRC1);

    clr(); mk(DA, SRC1, 16'h0800, 46); fq[32] = fq[32] ^ 8'h01; send();
    chk("t2_end_pulse", end_vec, 3'b010);
    idle(3);
    chk("t2_count", rxq.size(), 46);
    chk("t2_flipped", rxq[10], 8'h0b);
    chk("t2_good_bad", {n_good[7:0], n_bad[7:0]}, 16'h0001);

    clr(); mk(48'h112233445566, SRC1, 16'h0800, 46); send();
    chk("t3_pre_pulse", pre_vec, 3'b000);
    chk("t3_end_pulse", end_vec, 3'b001);
    idle(3);
    chk("t3_count", rxq.size(), 0);
    chk("t3_miss_bad", {n_miss[7:0], n_bad[7:0]}, 16'h0100);

    clr(); mk(48'hffffffffffff, 48'h0a0b0c0d0e0f, 16'h86dd, 46); send();
    chk("t3b_end_pulse", end_vec, 3'b100);
    idle(3);
    chk("t3b_count", rxq.size(), 46);
    chk("t3b_src", bus.rx_src_mac, 48'h0a0b0c0d0e0f);
    chk("t3b_type", bus.rx_frame_type, 16'h86dd);

    clr(); mk(DA, SRC1, 16'h0800, 46); fq[4] = 8'h55; send();
    chk("t4_end_pulse", end_vec, 3'b010);
    mk(DA, SRC1, 16'h0800, 46); send();
    chk("t4_b2b_end_pulse", end_vec, 3'b100);
    idle(3);
    chk("t4_count", rxq.size(), 46);
    chk("t4_good_bad", {n_good[7:0], n_bad[7:0]}, 16'h0101);

    clr(); mk(DA, SRC1, 16'h0800, 1); send();
    chk("t5_end_pulse", end_vec, 3'b100);
    idle(3);
    chk("t5_count", rxq.size(), 1);
    chk("t5_byte", rxq[0], 8'h00);
    chk("t5_sof_eof_idx", {sof_idx[7:0], eof_idx[7:0]}, 16'h0000);
    chk("t5_len", last_len, 1);

    clr(); mk(DA, SRC1, 16'h0800, 0); send();
    chk("t5b_end_pulse", end_vec, 3'b010);
    idle(3);
    chk("t5b_count_eof", {rxq.size(), n_eof}, 64'h0);

    clr(); mk(DA, SRC1, 16'h0800, 1500); send();
    chk("t7_end_pulse", end_vec, 3'b100);
    idle(3);
    chk("t7_count", rxq.size(), 1500);
    chk("t7_len", last_len, 1500);
    chk_payload("t7_bytes");

    clr(); mk(DA, SRC1, 16'h0800, 1502); send();
    chk("t7b_end_pulse", end_vec, 3'b010);
    idle(3);
    chk("t7b_count", rxq.size(), 1500);
    chk("t7b_eof_good", {n_eof[7:0], n_good[7:0]}, 16'h0000);

    clr(); mk(DA, SRC1, 16'h0800, 46);
    for (int i = 0; i < 42; i++) begin
      bus.mac_in = fq[i];
      bus.rx_ctl = 1'b1;
      @(posedge clk); #1;
    end
    chk("t6_pre_rst_valid", bus.rx_valid, 1'b1);
    chk("t6_pre_rst_src", bus.rx_src_mac, SRC1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_status", {bus.rx_valid, bus.rx_sof, bus.rx_eof, bus.frame_good, bus.frame_bad, bus.addr_miss}, 0);
    chk("t6_rst_hdr", {bus.rx_src_mac, bus.rx_frame_type}, 0);
    chk("t6_rst_data", bus.rx_data, 0);
    bus.rx_ctl = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);
    clr(); mk(DA, SRC1, 16'h0800, 46); send();
    chk("t6_end_pulse", end_vec, 3'b100);
    idle(3);
    chk("t6_count", rxq.size(), 46);

    chk("exclusive_pulses", n_multi, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/mac_rx.md
Name: mac_rx

Overview:
Receive-side MAC framer. It takes the byte-wide stream from the PHY receive path, qualified by rx_ctl, checks the preamble and filters on destination address. It captures the source MAC and frame type, streams the payload out with the 4-byte FCS stripped, and checks CRC-32. It is the counterpart of mac_tx and sits between the PHY nibble-to-byte stage and the user receive logic.

Parameters:
MAC_ADDR, 48'hdeadbeefcafe, own station address; byte 0 on the wire is MAC_ADDR[47:40]
PREAMBLE_BYTE, 8'hbc, value of every preamble byte (matches mac_tx)
PREAMBLE_LEN, 8, number of preamble bytes
MAX_PAYLOAD, 1500, maximum payload bytes; FCS is not counted
COUNTER_WIDTH, 11, width of the byte counters

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
mac_in  in  8  received byte
rx_ctl  in  1  high while a frame byte is present on mac_in
rx_data  out  8  payload byte
rx_valid  out  1  rx_data is valid this cycle
rx_sof  out  1  first payload byte of a frame
rx_eof  out  1  last payload byte of a frame
rx_src_mac  out  48  captured source MAC
rx_frame_type  out  16  captured type field; first byte received is [15:8]
rx_len  out  11  payload byte count, valid together with rx_eof
frame_good  out  1  one-cycle pulse: frame accepted and CRC matched
frame_bad  out  1  one-cycle pulse: CRC error, runt, oversize, or bad preamble
addr_miss  out  1  one-cycle pulse: frame dropped by the address filter

Behaviour:
- Reset (asynchronous, active-high): state goes to IDLE. All outputs are 0, including rx_src_mac and rx_frame_type. Counters, pipeline and CRC register are cleared.
- States: IDLE, PREAMBLE, DEST_MAC, SRC_MAC, FRAME_TYPE, DATA, CHECK, DISCARD.
- IDLE: when rx_ctl=1, go to PREAMBLE and count the current byte.
- PREAMBLE: each byte must equal PREAMBLE_BYTE.
  - On a mismatch or rx_ctl=0 before PREAMBLE_LEN bytes, go to DISCARD with the bad flag set.
  - After PREAMBLE_LEN good bytes, go to DEST_MAC and initialise the CRC register to 32'hffffffff.
- CRC: reflected CRC-32 (polynomial 0xEDB88320), updated one byte per cycle. It covers every byte from DEST_MAC through the final FCS byte.
- DEST_MAC: compare 6 bytes against MAC_ADDR and against 48'hffffffffffff (broadcast).
  - If neither matches after byte 6, go to DISCARD with the miss flag set.
  - If either matches, go to SRC_MAC.
- SRC_MAC: shift in 6 bytes, then go to FRAME_TYPE.
- FRAME_TYPE: take 2 bytes, then go to DATA.
- Header capture: rx_src_mac and rx_frame_type update only when FRAME_TYPE completes. They hold until the next frame's FRAME_TYPE completes.
- DATA: every byte is pushed into a 5-deep delay pipeline.
  - When a byte arrives and the pipeline already holds 5 bytes, the oldest byte is emitted: rx_valid=1, registered, one cycle after the arriving byte.
  - rx_sof=1 on the first emitted byte of the frame.
  - The payload counter counts emitted bytes.
- End of frame: rx_ctl=0 in DATA moves to CHECK.
- CHECK (one cycle):
  - If the pipeline holds 5 bytes, emit the oldest with rx_valid=1 and rx_eof=1 (and rx_sof=1 if it is also the first). rx_len is the final count. The other 4 bytes are the FCS and are dropped.
  - In the same cycle, frame_good=1 if the CRC register equals 32'hdebb20e3 (residue), otherwise frame_bad=1.
  - If the pipeline holds fewer than 5 bytes (runt: payload of 0 bytes), assert frame_bad only, with no rx_eof.
  - Then go to IDLE.
- Oversize: if the payload count would exceed MAX_PAYLOAD, go to DISCARD with the bad flag set. Bytes already emitted stay emitted; the user discards them on frame_bad.
- DISCARD: ignore bytes while rx_ctl=1. On rx_ctl=0, pulse frame_bad or addr_miss according to the flag, then go to IDLE. This pulse is one cycle later than the rx_ctl=0 sample.
- rx_ctl=0 during DEST_MAC, SRC_MAC or FRAME_TYPE: pulse frame_bad on the next cycle, then go to IDLE.
- Exclusivity: frame_good, frame_bad and addr_miss never assert together. Each frame produces exactly one of these three pulses, except a frame aborted in PREAMBLE, which produces frame_bad.
- Back-to-back frames: IDLE may accept a new rx_ctl=1 in the cycle right after CHECK or DISCARD. No gap cycle is required.
- Throughput: no backpressure; one byte per cycle.

Decomposition:
- Shared package mac_pkg: state encoding, PREAMBLE_BYTE, CRC32_POLY, CRC32_INIT, CRC32_RESIDUE, BROADCAST_MAC, and header lengths (6/6/2/4).
- One sub-module, mac_crc_rx: byte-wide CRC-32 step with ports clk, rst, init, en, data_in[7:0], crc_out[31:0].
- The delay pipeline is inline registers.

Test Plan:
1. Good unicast frame: 8x 8'hbc, dest de:ad:be:ef:ca:fe, src 02:00:00:00:00:01, type 0x0800, payload 00..2d (46 bytes), correct FCS -> 46 rx_valid bytes with rx_sof on 0x00, rx_eof on 0x2d, rx_len=46, frame_good=1, rx_frame_type=16'h0800, rx_src_mac=48'h020000000001.
2. Same frame with one payload bit flipped -> all 46 bytes emitted, frame_bad=1, frame_good=0.
3. Destination 11:22:33:44:55:66 -> no rx_valid; addr_miss pulses once, one cycle after rx_ctl falls. Broadcast ff:ff:ff:ff:ff:ff with a good FCS -> frame_good=1.
4. Preamble byte 4 = 8'h55 -> DISCARD, no rx_valid, frame_bad once at end. An immediately following good frame -> frame_good=1.
5. Header plus 1-byte payload plus FCS -> single byte with rx_sof=rx_eof=1, rx_len=1. Header plus FCS only (no payload) -> frame_bad, no rx_eof.
6. rst asserted mid-payload -> outputs 0 without waiting for a clock edge. After release, the next good frame -> frame_good=1.
